bsg_ds_core_arb: RTL and testbench

Round-robin arbiter that shares one core-side output port among NUM_CH downstream channel receivers. Each receiver presents a reassembled 32-bit word with a valid flag. The arbiter grants one channel for a burst of up to BURST_MAX words, then registers the word onto the core interface with a channel tag. It sits between the per-link downstream buffers and the core-clock consumer, and returns a yumi to the granted receiver so that receiver advances its read pointer.

---
 rtl/bsg_ds_pkg.sv | 18 +
 rtl/bsg_ds_rr_pick.sv | 35 +++
 rtl/bsg_ds_core_arb.sv | 129 ++++++++++++
 tb/tb_bsg_ds_core_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_ds_pkg.sv
// Shared types and defaults for the downstream-to-core arbitration slice.
package bsg_ds_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_BURST_MAX = 4;

  // Channel-id width; never narrower than one bit so a single channel still has a field.
  function automatic int ch_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_ds_rr_pick.sv
// Combinational find-first-valid, scanning upward from ptr_i with wrap to channel 0.
module bsg_ds_rr_pick
  import bsg_ds_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ID_W   = ch_id_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [ID_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_onehot_o,
  output logic [ID_W-1:0]   gnt_id_o,
  output logic              any_o
);

  int idx;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    gnt_onehot_o = '0;
    gnt_id_o     = '0;
    any_o        = 1'b0;
    idx          = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_o && req_i[idx]) begin
        any_o             = 1'b1;
        gnt_id_o          = ID_W'(idx);
        gnt_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_ds_core_arb.sv
// Round-robin burst arbiter: moves one word per cycle from a granted downstream
// channel into a registered core-side slot, returning a one-hot yumi upstream.
module bsg_ds_core_arb
  import bsg_ds_pkg::*;
#(
  parameter  int NUM_CH    = DEF_NUM_CH,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int BURST_MAX = DEF_BURST_MAX,
  localparam int ID_W      = ch_id_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic [NUM_CH-1:0]        ch_yumi_o,
  output logic                     core_valid_o,
  output logic [DATA_W-1:0]        core_data_o,
  output logic [ID_W-1:0]          core_ch_o,
  input  logic                     core_ready_i
);

  localparam int              CNT_W    = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [ID_W-1:0]  PTR_MAX  = ID_W'(NUM_CH - 1);

  arb_state_e          state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     lock_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                core_valid_q;
  logic [DATA_W-1:0]   core_data_q;
  logic [ID_W-1:0]     core_ch_q;

  logic [NUM_CH-1:0]   pick_onehot;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;

  logic                slot_free;
  logic                xfer;
  logic [ID_W-1:0]     sel_id;
  logic [NUM_CH-1:0]   sel_onehot;

  bsg_ds_rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req_i        (ch_valid_i),
    .ptr_i        (rr_ptr_q),
    .gnt_onehot_o (pick_onehot),
    .gnt_id_o     (pick_id),
    .any_o        (pick_any)
  );

  // Explicit wrap so non-power-of-two channel counts rotate correctly.
  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    slot_free  = !core_valid_q || core_ready_i;
    sel_id     = pick_id;
    sel_onehot = pick_onehot;
    xfer       = 1'b0;
    if (state_q == ARB_IDLE) begin
      xfer = slot_free && pick_any;
    end else begin
      sel_id             = lock_q;
      sel_onehot         = '0;
      sel_onehot[lock_q] = 1'b1;
      xfer               = slot_free && ch_valid_i[lock_q];
    end
    // A yumi during reset would let the upstream buffer drop a word nobody captured.
    if (rst) xfer = 1'b0;
  end

  assign ch_yumi_o = xfer ? sel_onehot : '0;

  // NOTE: all state below uses non-blocking '<=' so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      lock_q       <= '0;
      cnt_q        <= '0;
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      core_ch_q    <= '0;
    end else begin
      if (slot_free) begin
        core_valid_q <= xfer;
        if (xfer) begin
          core_data_q <= ch_data_i[sel_id*DATA_W +: DATA_W];
          core_ch_q   <= sel_id;
        end
      end

      case (state_q)
        ARB_IDLE: begin
          if (xfer) begin
            lock_q <= sel_id;
            cnt_q  <= CNT_W'(1);
            if (BURST_MAX > 1) state_q  <= ARB_BURST;
            else               rr_ptr_q <= ptr_inc(sel_id);
          end
        end
        ARB_BURST: begin
          if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q  <= ARB_IDLE;
              rr_ptr_q <= ptr_inc(lock_q);
            end
          end else if (slot_free) begin
            // Locked channel ran dry: give up the rest of the burst.
            state_q  <= ARB_IDLE;
            rr_ptr_q <= ptr_inc(lock_q);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign core_valid_o = core_valid_q;
  assign core_data_o  = core_data_q;
  assign core_ch_o    = core_ch_q;

endmodule

// File: tb/tb_bsg_ds_core_arb.sv
// Bench for bsg_ds_core_arb: directed scenarios plus random traffic, each cycle
// compared against a burst/ownership reference model.
module tb_bsg_ds_core_arb;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 32;
  localparam int BURST_MAX = 4;
  localparam int ID_W      = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_valid_i;
  logic [NUM_CH*DATA_W-1:0] ch_data_i;
  logic [NUM_CH-1:0]        ch_yumi_o;
  logic                     core_valid_o;
  logic [DATA_W-1:0]        core_data_o;
  logic [ID_W-1:0]          core_ch_o;
  logic                     core_ready_i;

  bsg_ds_core_arb #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_valid_i   (ch_valid_i),
    .ch_data_i    (ch_data_i),
    .ch_yumi_o    (ch_yumi_o),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_ch_o    (core_ch_o),
    .core_ready_i (core_ready_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus state
  logic [NUM_CH-1:0] vin;
  logic              rdy;
  bit                directed;
  int                rem [NUM_CH];
  int                seq [NUM_CH];
  logic [NUM_CH-1:0] last_yumi;
  int                yumi_cnt;
  int                dut_hs;

  // Reference model: who owns the port, how many words it has taken, where the
  // next fair search begins, and what the output slot should hold.
  int                owner;
  int                used;
  int                next_start;
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  int                m_ch;
  bit                m_free;
  int                exp_gnt;
  logic [NUM_CH-1:0] exp_yumi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] word_of(input int k);
    logic [DATA_W-1:0] base;
    base = (k == 1) ? 32'hA0 : (32'(k) << 24);
    return base + 32'(seq[k]);
  endfunction

  task automatic model_reset();
    owner      = -1;
    used       = 0;
    next_start = 0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_ch       = 0;
  endtask

  task automatic model_eval();
    int c;
    m_free   = !m_valid || rdy;
    exp_gnt  = -1;
    exp_yumi = '0;
    if (m_free) begin
      if (owner < 0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          c = (next_start + i) % NUM_CH;
          if (exp_gnt < 0 && vin[c]) exp_gnt = c;
        end
      end else if (vin[owner]) begin
        exp_gnt = owner;
      end
    end
    if (exp_gnt >= 0) exp_yumi[exp_gnt] = 1'b1;
  endtask

  task automatic model_commit();
    if (!m_free) return;
    if (owner < 0) begin
      if (exp_gnt >= 0) begin
        if (BURST_MAX > 1) begin
          owner = exp_gnt;
          used  = 1;
        end else begin
          next_start = (exp_gnt + 1) % NUM_CH;
        end
      end
    end else if (exp_gnt >= 0) begin
      used++;
      if (used == BURST_MAX) begin
        next_start = (owner + 1) % NUM_CH;
        owner      = -1;
      end
    end else begin
      next_start = (owner + 1) % NUM_CH;
      owner      = -1;
    end
    m_valid = (exp_gnt >= 0);
    if (exp_gnt >= 0) begin
      m_data = word_of(exp_gnt);
      m_ch   = exp_gnt;
      seq[exp_gnt]++;
      if (directed) rem[exp_gnt]--;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    if (directed)
      for (int k = 0; k < NUM_CH; k++) vin[k] = (rem[k] > 0);
    ch_valid_i   = vin;
    core_ready_i = rdy;
    for (int k = 0; k < NUM_CH; k++) ch_data_i[k*DATA_W +: DATA_W] = word_of(k);
    #1;
    model_eval();
    check("yumi", ch_yumi_o, exp_yumi);
    check("core_valid", core_valid_o, m_valid);
    check("core_data", core_data_o, m_data);
    check("core_ch", core_ch_o, m_ch);
    last_yumi = ch_yumi_o;
    yumi_cnt += $countones(ch_yumi_o);
    if (core_valid_o && core_ready_i) dut_hs++;
    model_commit();
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", core_valid_o, 0);
    check("rst_yumi", ch_yumi_o, 0);
    check("rst_data", core_data_o, 0);
    check("rst_ch", core_ch_o, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_rem();
    for (int k = 0; k < NUM_CH; k++) rem[k] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NUM_CH; k++) seq[k] = 0;
    clear_rem();
    model_reset();
    directed  = 1'b0;
    last_yumi = '0;
    yumi_cnt  = 0;
    dut_hs    = 0;

    // Power-on reset with every channel requesting: nothing may be yumi'd.
    rst          = 1'b1;
    vin          = '1;
    rdy          = 1'b1;
    ch_valid_i   = '1;
    core_ready_i = 1'b1;
    ch_data_i    = {4{32'hDEAD_BEEF}};
    #3;
    check("por_yumi", ch_yumi_o, 0);
    check("por_valid", core_valid_o, 0);
    check("por_data", core_data_o, 0);
    check("por_ch", core_ch_o, 0);
    ch_valid_i = '0;
    vin        = '0;
    #4;
    rst = 1'b0;

    // Single channel, six words.
    directed = 1'b1;
    clear_rem();
    rem[1] = 6;
    dut_hs = 0;
    repeat (12) run_cycle();
    check("single_hs", dut_hs, 6);

    // All channels always valid: one word every cycle.
    reset_pulse();
    directed = 1'b0;
    vin      = '1;
    rdy      = 1'b1;
    yumi_cnt = 0;
    repeat (16) run_cycle();
    check("full_tput", yumi_cnt, 16);

    // Backpressure mid-burst.
    reset_pulse();
    vin = '1;
    rdy = 1'b1;
    repeat (2) run_cycle();
    rdy      = 1'b0;
    yumi_cnt = 0;
    repeat (5) run_cycle();
    check("bp_no_yumi", yumi_cnt, 0);
    rdy = 1'b1;
    repeat (6) run_cycle();

    // Early release: ch2 runs dry after two words, ch3 waiting.
    reset_pulse();
    directed = 1'b1;
    clear_rem();
    rem[2] = 2;
    rem[3] = 3;
    repeat (3) run_cycle();
    check("early_bubble", last_yumi, 4'b0000);
    run_cycle();
    check("early_ch3", last_yumi, 4'b1000);
    repeat (4) run_cycle();

    // Wrap: pointer left at 3 by a full ch2 burst, then ch0 and ch3 compete.
    reset_pulse();
    clear_rem();
    rem[2] = 4;
    repeat (4) run_cycle();
    rem[0] = 2;
    rem[3] = 2;
    run_cycle();
    check("wrap_first", last_yumi, 4'b1000);
    repeat (3) run_cycle();
    check("wrap_second", last_yumi, 4'b0001);
    repeat (3) run_cycle();

    // Asynchronous reset in the middle of a burst.
    reset_pulse();
    clear_rem();
    rem[1] = 10;
    rem[2] = 10;
    repeat (2) run_cycle();
    check("mid_valid", core_valid_o, 1);
    reset_pulse();
    run_cycle();
    check("post_rst_lowest", last_yumi, 4'b0010);
    repeat (3) run_cycle();

    // Random traffic and backpressure.
    reset_pulse();
    directed = 1'b0;
    repeat (400) begin
      for (int k = 0; k < NUM_CH; k++) vin[k] = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 3) != 0);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
